// File: rtl/dmem_arb_pkg.sv
// Shared types and widths for the data-memory arbiter between the core and the DMA port.
package dmem_arb_pkg;

    localparam int unsigned ADDR_W         = 8;
    localparam int unsigned DATA_W         = 16;
    localparam int unsigned STARVE_MAX_DEF = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        DONE = 2'd2
    } arb_state_e;

    // DMA request record, frozen from capture until the arbiter returns to IDLE
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } dma_rec_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Core, DMA and memory-macro signals of the data-memory arbiter.
interface dmem_arbiter_if;
    import dmem_arb_pkg::*;

    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_wen;
    logic              cpu_ren;
    logic              hlt;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_ack;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_busy;
    logic              starve;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_rdata;

    // arbiter side
    modport slave (
        input  cpu_addr, cpu_wdata, cpu_wen, cpu_ren, hlt,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  mem_rdata,
        output cpu_rdata, dma_ack, dma_rdata, dma_busy, starve,
        output mem_addr, mem_wdata, mem_wen
    );

    // requesters and memory side
    modport master (
        output cpu_addr, cpu_wdata, cpu_wen, cpu_ren, hlt,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output mem_rdata,
        input  cpu_rdata, dma_ack, dma_rdata, dma_busy, starve,
        input  mem_addr, mem_wdata, mem_wen
    );

endinterface

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; at_max_o flags the saturation value.
module sat_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MAX   = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_max_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // clear has priority over increment
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != WIDTH'(MAX))) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign at_max_o = (count_q == WIDTH'(MAX));

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core (always wins) and a held DMA request.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    arb_state_e        state_q;
    dma_rec_t          req_q;
    logic              ack_q;
    logic              busy_q;
    logic [DATA_W-1:0] rdata_q;

    logic cpu_act_c;
    logic grant_c;
    logic starve_c;

    assign cpu_act_c = (bus.cpu_wen | bus.cpu_ren) & ~bus.hlt;
    assign grant_c   = (state_q == PEND) & ~cpu_act_c;

    // Memory port mux: core first, then a granted DMA, otherwise park at zero
    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wen   = 1'b0;
        if (cpu_act_c) begin
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
            bus.mem_wen   = bus.cpu_wen;
        end else if (grant_c) begin
            bus.mem_addr  = req_q.addr;
            bus.mem_wdata = req_q.wdata;
            bus.mem_wen   = req_q.we;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            req_q   <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.dma_req) begin
                        req_q   <= '{we: bus.dma_we, addr: bus.dma_addr, wdata: bus.dma_wdata};
                        state_q <= PEND;
                        busy_q  <= 1'b1;
                    end
                end
                PEND: begin
                    if (grant_c) begin
                        if (!req_q.we) begin
                            rdata_q <= bus.mem_rdata;
                        end
                        state_q <= DONE;
                        ack_q   <= 1'b1;
                    end
                end
                DONE: begin
                    // a request still high here is only sampled in the next IDLE cycle
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(
        .WIDTH (CNT_W),
        .MAX   (STARVE_MAX)
    ) u_starve_cnt (
        .clk      (clk),
        .reset    (reset),
        .inc_i    ((state_q == PEND) && cpu_act_c),
        .clr_i    (grant_c || (state_q == IDLE)),
        .at_max_o (starve_c)
    );

    assign bus.cpu_rdata = bus.mem_rdata;
    assign bus.dma_ack   = ack_q;
    assign bus.dma_rdata = rdata_q;
    assign bus.dma_busy  = busy_q;
    assign bus.starve    = starve_c;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the 256×16 single-port data memory between the processor core and a secondary DMA requester (serial loader / debug port). The processor always wins, because it cannot be stalled and expects read data in the same cycle. The DMA request is captured, held, and serviced in the first cycle the processor leaves the memory idle. The block sits between the core's data-memory port and the memory macro, replacing the direct connection.

## Interface
- ADDR_W, 8, data memory address width
- DATA_W, 16, data word width
- STARVE_MAX, 15, denied-cycle count at which `starve` asserts (saturating)

Ports:
- clk  in  1  single system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- cpu_addr  in  ADDR_W  processor data address (already gated by its enables)
- cpu_wdata  in  DATA_W  processor write data
- cpu_wen  in  1  processor write enable (core's Dataw_en)
- cpu_ren  in  1  processor read enable (core's Datar_en, exported for this block)
- hlt  in  1  core halted; the processor port is ignored while high
- cpu_rdata  out  DATA_W  memory read data to core
- dma_req  in  1  DMA request, level; held until `dma_ack`
- dma_we  in  1  1 = write, 0 = read
- dma_addr  in  ADDR_W  DMA address
- dma_wdata  in  DATA_W  DMA write data
- dma_ack  out  1  one-cycle completion pulse
- dma_rdata  out  DATA_W  registered read data, valid while `dma_ack`=1
- dma_busy  out  1  request captured and not yet acknowledged
- starve  out  1  pending DMA denied for ≥ STARVE_MAX consecutive cycles
- mem_addr  out  ADDR_W  to memory
- mem_wdata  out  DATA_W  to memory
- mem_wen  out  1  to memory
- mem_rdata  in  DATA_W  combinational read data from memory

## Operation
- `cpu_act` = (cpu_wen | cpu_ren) & ~hlt.
- FSM states:
  - IDLE: if `dma_req`=1, capture `dma_we`, `dma_addr` and `dma_wdata` into the request register and go to PEND.
  - PEND: `dma_grant` = ~cpu_act. On a grant, capture `mem_rdata` into `dma_rdata` (reads only) and go to DONE; otherwise stay in PEND.
  - DONE: `dma_ack`=1, then go to IDLE.
- `dma_req` is sampled only in IDLE. The requester drops or changes its request in the `dma_ack` cycle; a request still high in DONE is seen again only in the following IDLE cycle.
- Memory mux, combinational:
  - if `cpu_act`: mem_* = cpu_addr, cpu_wdata, cpu_wen;
  - else if `dma_grant`: mem_* = captured addr, captured wdata, captured we;
  - else: mem_addr = 0, mem_wdata = 0, mem_wen = 0.
- `cpu_rdata` = `mem_rdata` at all times.
- `dma_busy` = state ∈ {PEND, DONE}.
- Starvation counter:
  - increments each PEND cycle with `cpu_act`=1;
  - saturates at STARVE_MAX;
  - clears on grant and in IDLE.
  - `starve` = (count == STARVE_MAX). It is informational only: the arbiter never preempts the processor.
- Captured request fields are frozen from capture until return to IDLE. Input changes during PEND are ignored.

## Timing
- Reset values: state IDLE, `dma_ack` 0, `dma_rdata` 0, `dma_busy` 0, `starve` 0, counter 0, request register 0. Memory outputs follow the cpu inputs combinationally.
- Minimum DMA latency: request seen at edge N, grant during cycle N+1, `dma_ack` during cycle N+2. Peak throughput is one access per 3 cycles.
- Processor accesses have zero added latency and pass through combinationally in every state.
- Simultaneous `cpu_act` and PEND: the processor is served and DMA waits, with no memory cycle lost.
- `hlt`=1: the processor port is masked, so a pending DMA is granted in its first PEND cycle.
- Reset asserted mid-operation (PEND or DONE): the request is dropped, no `dma_ack` is issued, and the requester must reissue.
- `starve` rises on the edge where the count reaches STARVE_MAX and falls on the edge after the grant.

## Structure
- Shared package `dmem_arb_pkg`:
  - state enum IDLE/PEND/DONE;
  - ADDR_W/DATA_W defaults;
  - request-record struct {we, addr, wdata}.
- One sub-module `sat_counter` (parameterised width and max, with inc/clr inputs and an `at_max` output), reused for the starvation count.

## Test plan
- Idle core, DMA write addr 0x10 data 0xBEEF: `mem_wen` is high with 0x10/0xBEEF one cycle after `dma_req`, and `dma_ack` follows the next cycle. A subsequent DMA read of 0x10 returns `dma_rdata`=0xBEEF with `dma_ack`.
- Core reads 0x20 every cycle for 5 cycles while a DMA read is pending: the DMA is granted in the first core-idle cycle, `cpu_rdata` is correct throughout, and `dma_busy` stays high for 7 cycles.
- Core busy for 20 cycles with a DMA pending: `starve`=1 after 15 denied cycles, holds, and clears the edge after the grant.
- `hlt`=1 with `cpu_wen`=1: DMA write to 0x05 is granted immediately, the memory sees the DMA address only, and the core write is suppressed.
- Reset pulled low while in PEND: all outputs return to reset values asynchronously, no `dma_ack` ever appears, and a reissued request completes normally.
- `dma_req` held high across `dma_ack`: the second access starts only from IDLE, giving exactly 3 cycles between acks.
